// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder step per cycle, registered Sum/Carry.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_ps, w_ps;
   logic [CW-1:0]    r_cnt;
   logic             r_c, w_s1, w_c1, w_bit, w_c2, w_cout, w_last, w_load;
   // full adder as two half-adders plus an OR of their carries
   assign w_s1   = r_a[0] ^ r_b[0];
   assign w_c1   = r_a[0] & r_b[0];
   assign w_bit  = w_s1 ^ r_c;
   assign w_c2   = w_s1 & r_c;
   assign w_cout = w_c1 | w_c2;
   assign w_ps   = {w_bit, r_ps[WIDTH-1:1]};
   assign w_last = r_cnt == CW'(WIDTH - 1);
   assign w_load = Start && (r_state == IDLE || r_state == DONE);
   assign Busy   = r_state == ADD;
   assign Done   = r_state == DONE;
   always_comb begin
      w_next = r_state == ADD ? (w_last ? DONE : ADD) : (Start ? ADD : IDLE);
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_ps  <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
         Sum   <= '0;
         Carry <= 1'b0;
      end else if (w_load) begin
         r_a   <= A;
         r_b   <= B;
         r_ps  <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == ADD) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_ps  <= w_ps;
         r_c   <= w_cout;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            Sum   <= w_ps;
            Carry <= w_cout;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;
   logic       Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic       Busy, Done, Carry;
   logic [7:0] Sum;
   logic [8:0] q[$];
   int         n_chk = 0, n_fail = 0;

   serial_adder #(.WIDTH(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .Sum(Sum), .Carry(Carry)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // call #1 after an edge of an addition; lat = edges still to go until Done
   task automatic wait_done(input string tag, input int lat);
      int cyc = 0, busy = 0;
      logic [8:0] e;
      busy += int'(Busy);
      while (cyc < 20) begin
         @(posedge Clk); #1;
         cyc++;
         if (Done) break;
         busy += int'(Busy);
      end
      chk({tag, " done latency"}, cyc, lat);
      chk({tag, " busy cycles"}, busy, lat);
      if (Done) begin
         chk({tag, " queue"}, q.size() > 0, 1);
         e = q.size() > 0 ? q.pop_front() : 9'h1xx;
         chk({tag, " result"}, {Carry, Sum}, e);
      end
   endtask

   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge Clk);
      A = a; B = b; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      q.push_back(ref_add(a, b));
   endtask

   initial begin
      logic [7:0] ba[3] = '{8'h01, 8'h80, 8'h7F};
      logic [7:0] bb[3] = '{8'h01, 8'h80, 8'h01};
      #1;
      chk("reset outputs", {Busy, Done, Carry, Sum}, 0);
      @(negedge Clk); Reset = 1'b0;
      start_op(8'h00, 8'h00); wait_done("00+00", 8);
      @(posedge Clk); #1;
      chk("done one cycle", {Busy, Done}, 0);
      start_op(8'hFF, 8'h01); wait_done("FF+01", 8);
      start_op(8'hFF, 8'hFF); wait_done("FF+FF", 8);
      start_op(8'hA5, 8'h5A); wait_done("A5+5A", 8);
      start_op(8'h10, 8'h20);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Start = 1'b1; A = 8'hFF; B = 8'hFF;
      chk("sum held during add", {Carry, Sum}, 9'h0FF);
      @(posedge Clk); #1;
      Start = 1'b0;
      chk("start ignored busy", Busy, 1);
      wait_done("10+20 ignore", 5);
      start_op(8'h55, 8'h11);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      #2 Reset = 1'b1;
      #1;
      chk("async reset", {Busy, Done, Carry, Sum}, 0);
      q.pop_back();
      @(posedge Clk); #1;
      chk("reset no done", {Busy, Done, Carry, Sum}, 0);
      @(negedge Clk);
      Reset = 1'b0; Start = 1'b1; A = 8'h03; B = 8'h04;
      @(posedge Clk); #1;
      Start = 1'b0;
      q.push_back(ref_add(8'h03, 8'h04));
      wait_done("03+04 after reset", 8);
      @(negedge Clk);
      Start = 1'b1; A = ba[0]; B = bb[0];
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         q.push_back(ref_add(ba[i], bb[i]));
         chk($sformatf("b2b%0d busy at accept", i), Busy, 1);
         if (i < 2) begin
            A = ba[i+1]; B = bb[i+1];
         end else Start = 1'b0;
         wait_done($sformatf("b2b%0d", i), 8);
      end
      @(posedge Clk); #1;
      chk("idle after b2b", {Busy, Done}, 0);
      chk("queue drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
